jkff_sched: RTL and testbench
=============================

JKFF_SCHED -- requirements
Module: jkff_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the JK datapath (2..16).
REQ-002 Parameter WLEN, default 256, SHALL set the bitstream window length in cycles per grant (2..65535).
REQ-003 Derived widths SHALL be IDW = clog2(NREQ) and CW = clog2(WLEN+1).
REQ-004 clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester request level.
REQ-007 j_in  input  NREQ  per-requester J bitstream.
REQ-008 k_in  input  NREQ  per-requester K bitstream.
REQ-009 gnt  output  NREQ  one-hot grant, high only in RUN.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  result consumer ready.
REQ-013 res_id  output  IDW  index of the requester whose window produced the result.
REQ-014 res_cnt  output  CW  count of ones in the JK output stream over the window.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, RUN and DONE.
REQ-016 IDLE: when req is nonzero, the FSM SHALL latch the winner into cur_id and move to CLEAR; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration: the winner SHALL be the first set req bit found by searching upward from rr_ptr with wrap-around.
REQ-018 CLEAR: the FSM SHALL clear the JK state q and the counter in one cycle, then move to RUN.
REQ-019 RUN: the FSM SHALL stay for exactly WLEN cycles and drive gnt[cur_id]=1.
REQ-020 RUN update: each RUN cycle SHALL compute q_next from j_in[cur_id] and k_in[cur_id] as 00 hold, 10 set, 01 clear, 11 toggle, then load q with q_next and add q_next to cnt.
REQ-021 DONE: res_valid SHALL be 1, with res_id=cur_id and res_cnt=cnt held stable.
REQ-022 Leaving DONE: on res_valid && res_ready the FSM SHALL set rr_ptr to (cur_id+1) mod NREQ and return to IDLE.
REQ-023 Latency: with res_ready=1, res_valid SHALL go high WLEN+2 cycles after the edge that samples req.
REQ-024 Request drop: deasserting req[cur_id] during CLEAR or RUN SHALL NOT abort the window, which completes normally.
REQ-025 Hold-off: no new grant SHALL be issued while the FSM is in DONE; back-to-back windows are separated by one IDLE cycle.
REQ-026 Width: cnt SHALL saturate-free cover 0..WLEN; an all-ones window SHALL give res_cnt=WLEN.

Reset
REQ-027 While rst_n=0, the block SHALL force state=IDLE, q=0, cnt=0, rr_ptr=0, cur_id=0, gnt=0, busy=0, res_valid=0, res_id=0 and res_cnt=0.
REQ-028 Reset asserted mid-window SHALL discard the partial result, and no res_valid SHALL appear for that window.

Configuration
REQ-029 With JKFF_SCHED_FIXPRIO_EN defined, arbitration SHALL be fixed-priority (lowest set index wins) and rr_ptr SHALL be removed.
REQ-030 Without JKFF_SCHED_FIXPRIO_EN, arbitration SHALL be round-robin as in REQ-017 and REQ-022.

Structure
REQ-031 Package jkff_sched_pkg SHALL hold the FSM state typedef (sched_state_t) and the JK encoding constants.
REQ-032 Sub-module jk_cell SHALL hold the JK state q with its synchronous clear and enable inputs and q_next output; it SHALL be instantiated once.

Verification
REQ-033 Reset: assert rst_n=0 during RUN -> all outputs 0 next cycle, and no res_valid until a fresh request.
REQ-034 WLEN=256, req=4'b0100, J=1, K=0 -> res_id=2, res_cnt=256, res_valid exactly 258 cycles after the req edge.
REQ-035 WLEN=256, req=4'b0001, J=K=1 -> q toggles 1,0,1,... and res_cnt=128.
REQ-036 req=4'b1111 held, res_ready=1 -> grant order 0,1,2,3,0; with JKFF_SCHED_FIXPRIO_EN -> 0,0,0.
REQ-037 res_ready=0 for 10 cycles in DONE -> res_valid, res_id and res_cnt stable, gnt=0, busy=1; the result is accepted on the first cycle with res_ready=1.
REQ-038 req[1] dropped at RUN cycle 5 with J=1, K=0 -> window completes with res_cnt=256 and res_id=1.

Source files
------------

// File: rtl/jkff_sched_pkg.sv
// Shared types for the JK bitstream scheduler: FSM state encoding and JK input codes.
// Imported by jk_cell and jkff_sched.
package jkff_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // JK input codes, packed as {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            JK_HOLD: r = q;
            JK_SET:  r = 1'b1;
            JK_CLR:  r = 1'b0;
            default: r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous clear and update enable; q_next is the
// value the flop would load this cycle, exposed so the caller can accumulate it.
module jk_cell
    import jkff_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q_next
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_next = jk_next(q_q, j, k);
    end

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 1'b0;
        end else if (en) begin
            q_d = q_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/jkff_sched.sv
// Time-shares one JK flip-flop among NREQ requesters, one WLEN-cycle window per grant,
// and reports the count of ones. Define JKFF_SCHED_FIXPRIO_EN for fixed-priority arbitration.
//
// state | meaning
// IDLE  | wait for a registered request, latch the arbitration winner
// CLEAR | clear JK state and ones counter, load window timer
// RUN   | grant cur_id, clock its J/K stream through the cell for WLEN cycles
// DONE  | hold result until res_ready
module jkff_sched
    import jkff_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int WLEN = 256,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(WLEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] j_in,
    input  logic [NREQ-1:0] k_in,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [IDW-1:0]  res_id,
    output logic [CW-1:0]   res_cnt
);

    sched_state_t    state_q, state_d;
    logic [NREQ-1:0] req_q, req_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   tmr_q, tmr_d;
`ifndef JKFF_SCHED_FIXPRIO_EN
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
`endif

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    int              idx;
    logic            jk_clr;
    logic            jk_en;
    logic            jk_q_next;
    logic            accept;

    // req is registered once; arbitration works on the registered copy
    always_comb begin
        req_d = req;
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef JKFF_SCHED_FIXPRIO_EN
            idx = i;
`else
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
`endif
            if (!win_found && req_q[IDW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    assign accept = (state_q == ST_DONE) && res_ready;
    assign jk_clr = (state_q == ST_CLEAR);
    assign jk_en  = (state_q == ST_RUN);

    jk_cell u_jk (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (jk_clr),
        .en     (jk_en),
        .j      (j_in[cur_id_q]),
        .k      (k_in[cur_id_q]),
        .q_next (jk_q_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tmr_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt       = '0;
        busy      = (state_q != ST_IDLE);
        res_valid = (state_q == ST_DONE);
        res_id    = '0;
        res_cnt   = '0;
        if (state_q == ST_RUN) begin
            gnt[cur_id_q] = 1'b1;
        end
        if (state_q == ST_DONE) begin
            res_id  = cur_id_q;
            res_cnt = cnt_q;
        end
    end

    // Window timer counts down from WLEN; the RUN cycle that sees 1 is the last one.
    always_comb begin
        cur_id_d = cur_id_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
`ifndef JKFF_SCHED_FIXPRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    cur_id_d = win_idx;
                end
            end
            ST_CLEAR: begin
                cnt_d = '0;
                tmr_d = CW'(WLEN);
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(jk_q_next);
                tmr_d = tmr_q - CW'(1);
            end
            ST_DONE: begin
`ifndef JKFF_SCHED_FIXPRIO_EN
                if (accept) begin
                    rr_ptr_d = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + IDW'(1);
                end
`endif
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            cur_id_q <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
        end else begin
            req_q    <= req_d;
            cur_id_q <= cur_id_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
        end
    end

`ifndef JKFF_SCHED_FIXPRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_jkff_sched.sv
// Scoreboard bench for jkff_sched; expected windows are queued at request time and
// popped when res_valid appears. Honors JKFF_SCHED_FIXPRIO_EN for grant order.
module tb_jkff_sched;

    localparam int NREQ = 4;
    localparam int WLEN = 256;
    localparam int IDW  = 2;
    localparam int CW   = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] j_in;
    logic [NREQ-1:0] k_in;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            res_valid;
    logic            res_ready;
    logic [IDW-1:0]  res_id;
    logic [CW-1:0]   res_cnt;

    jkff_sched #(.NREQ(NREQ), .WLEN(WLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .j_in      (j_in),
        .k_in      (k_in),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_cnt   (res_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int cnt;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef JKFF_SCHED_FIXPRIO_EN
    localparam int NWIN = 3;
    int ord [NWIN] = '{0, 0, 0};
`else
    localparam int NWIN = 5;
    int ord [NWIN] = '{0, 1, 2, 3, 0};
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int model_cnt(input logic j, input logic k);
        logic q;
        int   n;
        q = 1'b0;
        n = 0;
        for (int c = 0; c < WLEN; c++) begin
            if (j && k)  q = ~q;
            else if (j)  q = 1'b1;
            else if (k)  q = 1'b0;
            n += int'(q);
        end
        return n;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: req is sampled at the next posedge (cyc+1) and the
    // result must be visible WLEN+2 posedges after that.
    task automatic start(input logic [NREQ-1:0] r, input int id, input bit pulse);
        exp_t e;
        req   = r;
        e.id  = id;
        e.cnt = model_cnt(j_in[id], k_in[id]);
        e.lat = cyc + 1 + WLEN + 2;
        sb.push_back(e);
        if (pulse) begin
            tick();
            req = '0;
        end
    endtask

    task automatic wait_gnt(input string tag, input logic [NREQ-1:0] exp_gnt);
        int b = 0;
        while (gnt == '0 && b < 50) begin
            tick();
            b++;
        end
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    endtask

    task automatic wait_result(input string tag, input bit chk_lat);
        exp_t e;
        int   b = 0;
        while (!res_valid && b < 2000) begin
            tick();
            b++;
        end
        if (!res_valid) begin
            chk({tag, "_timeout"}, 32'(res_valid), 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(res_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"}, 32'(res_id), 32'(e.id));
            chk({tag, "_cnt"}, 32'(res_cnt), 32'(e.cnt));
            if (chk_lat) chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_id"}, 32'(res_id), 32'd0);
        chk({tag, "_cnt"}, 32'(res_cnt), 32'd0);
    endtask

    initial begin
        int seen_valid;
        rst_n     = 1'b0;
        req       = '0;
        j_in      = '0;
        k_in      = '0;
        res_ready = 1'b1;
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // single requester, J=1 K=0: all ones, latency WLEN+2
        j_in = 4'b1111;
        k_in = 4'b0000;
        start(4'b0100, 2, 1'b1);
        wait_result("set_win", 1'b1);
        tick(2);

        // toggle stream, rr pointer wraps from 3 to 0
        j_in = 4'b1111;
        k_in = 4'b1111;
        start(4'b0001, 0, 1'b1);
        wait_gnt("tgl", 4'b0001);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("tgl_q", 32'(dut.u_jk.q_q), (t % 2 == 0) ? 32'd1 : 32'd0);
        end
        wait_result("tgl_win", 1'b1);
        tick(2);

        // all requesters held; arbitration order and one IDLE cycle between windows
        rst_n = 1'b0;
        tick();
        chk_all_zero("rst2");
        rst_n = 1'b1;
        tick();
        j_in = 4'b1011;
        k_in = 4'b0110;
        for (int w = 0; w < NWIN; w++) start(4'b1111, ord[w], 1'b0);
        for (int w = 0; w < NWIN; w++) begin
            if (w == NWIN - 1) req = '0;
            wait_result("rr_win", 1'b0);
            tick();
            chk("rr_gap_idle", 32'(busy), 32'd0);
            tick();
            chk("rr_gap_next", 32'(busy), (w == NWIN - 1) ? 32'd0 : 32'd1);
        end

        // result held while consumer stalls
        res_ready = 1'b0;
        j_in = 4'b1000;
        k_in = 4'b0000;
        start(4'b1000, 3, 1'b1);
        wait_result("stall_win", 1'b1);
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_id", 32'(res_id), 32'd3);
            chk("stall_cnt", 32'(res_cnt), 32'(WLEN));
            chk("stall_gnt", 32'(gnt), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        res_ready = 1'b1;
        tick();
        chk("stall_accept_valid", 32'(res_valid), 32'd0);
        chk("stall_accept_busy", 32'(busy), 32'd0);
        tick();

        // request dropped at RUN cycle 5 must not abort the window
        j_in = 4'b0010;
        k_in = 4'b0000;
        start(4'b0010, 1, 1'b0);
        wait_gnt("drop", 4'b0010);
        tick(4);
        req = '0;
        wait_result("drop_win", 1'b1);
        tick(2);

        // reset in the middle of RUN discards the window
        j_in = 4'b1111;
        k_in = 4'b1111;
        req  = 4'b0001;
        tick();
        req  = '0;
        wait_gnt("abort", 4'b0001);
        tick(20);
        rst_n = 1'b0;
        tick();
        chk_all_zero("abort_rst");
        rst_n = 1'b1;
        seen_valid = 0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (res_valid) seen_valid++;
        end
        chk("abort_no_valid", 32'(seen_valid), 32'd0);
        start(4'b0001, 0, 1'b1);
        wait_result("post_abort_win", 1'b1);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
